// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory responder:
// FSM encoding, build defaults and the address check.
package mips_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } memStateT;

   localparam int unsigned DEF_DEPTH = 64;
   localparam int unsigned DEF_WAIT_CYCLES = 2;

   // Misaligned or past the last word.
   function automatic logic addrErr(
      input logic [31:0] addr,
      input int unsigned depth
   );
      return (addr[1:0] != 2'b00)
          || ({2'b00, addr[31:2]} >= depth);
   endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Word storage for the responder: one write port,
// one combinational read port, cleared by reset.
module dmem_array
   import mips_mem_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic          CLK,
   input  logic          Reset,
   input  logic          we,
   input  logic [AW-1:0] wAddr,
   input  logic [31:0]   wData,
   input  logic [AW-1:0] rAddr,
   output logic [31:0]   rData,
   output logic [15:0]   word0Lo
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[wAddr] <= wData;
      end
   end

   assign rData   = mem[rAddr];
   assign word0Lo = mem[0][15:0];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store,
// waits WAIT_CYCLES, then holds the response until taken.
module dmem_responder
   import mips_mem_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [15:0] test_value
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT =
      (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   memStateT      stateQ, stateD;
   logic [3:0]    cntQ, cntD;
   logic [AW-1:0] idxQ;
   logic [31:0]   wdataQ;
   logic          writeQ, errQ;
   logic          accept, memWe, reqErr;
   logic [AW-1:0] wIdx;
   logic [31:0]   wData, rdWord;

   assign reqErr = addrErr(req_addr, DEPTH);

   always_comb begin
      stateD = stateQ;
      cntD   = cntQ;
      accept = 1'b0;
      memWe  = 1'b0;
      unique case (stateQ)
         IDLE: begin
            if (req_valid) begin
               accept = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  stateD = RESP;
                  memWe  = req_write && !reqErr;
               end else begin
                  stateD = WAIT;
                  cntD   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (cntQ == 4'd0) begin
               stateD = RESP;
               memWe  = writeQ && !errQ;
            end else begin
               cntD = cntQ - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) stateD = IDLE;
         end
         default: stateD = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         stateQ <= IDLE;
         cntQ   <= '0;
         idxQ   <= '0;
         wdataQ <= '0;
         writeQ <= 1'b0;
         errQ   <= 1'b0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
         if (accept) begin
            idxQ   <= req_addr[AW+1:2];
            wdataQ <= req_wdata;
            writeQ <= req_write;
            errQ   <= reqErr;
         end
      end
   end

   // Zero-wait stores commit straight from the request bus.
   assign wIdx  = (stateQ == IDLE) ? req_addr[AW+1:2] : idxQ;
   assign wData = (stateQ == IDLE) ? req_wdata : wdataQ;

   dmem_array #(.DEPTH(DEPTH)) uArray (
      .CLK     (CLK),
      .Reset   (Reset),
      .we      (memWe),
      .wAddr   (wIdx),
      .wData   (wData),
      .rAddr   (idxQ),
      .rData   (rdWord),
      .word0Lo (test_value)
   );

   assign req_ready = (stateQ == IDLE);
   assign rsp_valid = (stateQ == RESP);
   assign rsp_err   = (stateQ == RESP) && errQ;
   assign rsp_rdata =
      (stateQ == RESP && !writeQ && !errQ) ? rdWord : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: default build
// plus a zero-wait build.
module tb_dmem_responder;

   logic        CLK = 1'b0;
   logic        Reset = 1'b0;

   logic        reqValid = 1'b0, reqWrite = 1'b0;
   logic [31:0] reqAddr = '0, reqWdata = '0;
   logic        reqReady, rspValid, rspReady = 1'b1;
   logic [31:0] rspRdata;
   logic        rspErr;
   logic [15:0] testValue;

   logic        zReqValid = 1'b0, zReqWrite = 1'b0;
   logic [31:0] zReqAddr = '0, zReqWdata = '0;
   logic        zReqReady, zRspValid, zRspReady = 1'b1;
   logic [31:0] zRspRdata;
   logic        zRspErr;
   logic [15:0] zTestValue;

   int nVec = 0;
   int nErr = 0;

   always #5 CLK = ~CLK;

   dmem_responder dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .req_valid  (reqValid),
      .req_write  (reqWrite),
      .req_addr   (reqAddr),
      .req_wdata  (reqWdata),
      .req_ready  (reqReady),
      .rsp_valid  (rspValid),
      .rsp_ready  (rspReady),
      .rsp_rdata  (rspRdata),
      .rsp_err    (rspErr),
      .test_value (testValue)
   );

   dmem_responder #(.WAIT_CYCLES(0)) dutZ (
      .CLK        (CLK),
      .Reset      (Reset),
      .req_valid  (zReqValid),
      .req_write  (zReqWrite),
      .req_addr   (zReqAddr),
      .req_wdata  (zReqWdata),
      .req_ready  (zReqReady),
      .rsp_valid  (zRspValid),
      .rsp_ready  (zRspReady),
      .rsp_rdata  (zRspRdata),
      .rsp_err    (zRspErr),
      .test_value (zTestValue)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Present a request, accept it, and step to RESP
   // (two wait states in the default build).
   task automatic issue(input logic w,
                        input logic [31:0] a,
                        input logic [31:0] d);
      reqValid = 1'b1;
      reqWrite = w;
      reqAddr  = a;
      reqWdata = d;
      tick();
      reqValid = 1'b0;
      reqAddr  = 32'hFFFF_FFFF;
      reqWdata = 32'hDEAD_DEAD;
      tick();
      tick();
   endtask

   initial begin
      #12 Reset = 1'b1;
      tick();
      chk("rst_req_ready", {31'd0, reqReady}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rspValid}, 32'd0);
      chk("rst_rdata", rspRdata, 32'd0);
      chk("rst_err", {31'd0, rspErr}, 32'd0);
      chk("rst_test_value", {16'd0, testValue}, 32'd0);

      // Store BEEF to word 0 with timing checks
      reqValid = 1'b1;
      reqWrite = 1'b1;
      reqAddr  = 32'h0;
      reqWdata = 32'h0000_BEEF;
      tick();
      reqValid = 1'b0;
      chk("st0_w1_valid", {31'd0, rspValid}, 32'd0);
      chk("st0_w1_ready", {31'd0, reqReady}, 32'd0);
      tick();
      chk("st0_w2_valid", {31'd0, rspValid}, 32'd0);
      tick();
      chk("st0_rsp_valid", {31'd0, rspValid}, 32'd1);
      chk("st0_rsp_err", {31'd0, rspErr}, 32'd0);
      chk("st0_rsp_rdata", rspRdata, 32'd0);
      chk("st0_test_value", {16'd0, testValue}, 32'h0000_BEEF);
      tick();
      chk("st0_idle_ready", {31'd0, reqReady}, 32'd1);
      chk("st0_idle_valid", {31'd0, rspValid}, 32'd0);

      // Store then load word 4 (addr 0x10)
      issue(1'b1, 32'h10, 32'h1234_5678);
      chk("st10_valid", {31'd0, rspValid}, 32'd1);
      chk("st10_rdata", rspRdata, 32'd0);
      tick();
      chk("b2b_idle_ready", {31'd0, reqReady}, 32'd1);
      issue(1'b0, 32'h10, 32'h0);
      chk("ld10_valid", {31'd0, rspValid}, 32'd1);
      chk("ld10_rdata", rspRdata, 32'h1234_5678);
      chk("ld10_err", {31'd0, rspErr}, 32'd0);
      tick();

      // Error cases
      issue(1'b0, 32'h6, 32'h0);
      chk("mis_err", {31'd0, rspErr}, 32'd1);
      chk("mis_rdata", rspRdata, 32'd0);
      tick();
      issue(1'b1, 32'h100, 32'hFFFF_FFFF);
      chk("oor_err", {31'd0, rspErr}, 32'd1);
      chk("oor_rdata", rspRdata, 32'd0);
      tick();
      chk("oor_test_value", {16'd0, testValue}, 32'h0000_BEEF);
      issue(1'b0, 32'h0, 32'h0);
      chk("oor_ld0_rdata", rspRdata, 32'h0000_BEEF);
      chk("oor_ld0_err", {31'd0, rspErr}, 32'd0);
      tick();
      issue(1'b1, 32'h12, 32'hFFFF_FFFF);
      chk("mis_st_err", {31'd0, rspErr}, 32'd1);
      tick();
      issue(1'b0, 32'h10, 32'h0);
      chk("mis_st_unch", rspRdata, 32'h1234_5678);
      tick();

      // Response stall with rsp_ready low
      rspReady = 1'b0;
      issue(1'b0, 32'h10, 32'h0);
      chk("stall_valid0", {31'd0, rspValid}, 32'd1);
      chk("stall_rdata0", rspRdata, 32'h1234_5678);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_valid", {31'd0, rspValid}, 32'd1);
         chk("stall_rdata", rspRdata, 32'h1234_5678);
         chk("stall_ready", {31'd0, reqReady}, 32'd0);
      end
      rspReady = 1'b1;
      tick();
      chk("stall_idle_ready", {31'd0, reqReady}, 32'd1);
      chk("stall_idle_valid", {31'd0, rspValid}, 32'd0);
      chk("stall_idle_rdata", rspRdata, 32'd0);
      chk("stall_idle_err", {31'd0, rspErr}, 32'd0);

      // Reset during WAIT of a store to word 0
      reqValid = 1'b1;
      reqWrite = 1'b1;
      reqAddr  = 32'h0;
      reqWdata = 32'h0000_CAFE;
      tick();
      reqValid = 1'b0;
      tick();
      #2 Reset = 1'b0;
      #1;
      chk("rstw_ready", {31'd0, reqReady}, 32'd1);
      chk("rstw_valid", {31'd0, rspValid}, 32'd0);
      chk("rstw_test_value", {16'd0, testValue}, 32'd0);
      #2 Reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rstw_no_rsp", {31'd0, rspValid}, 32'd0);
         chk("rstw_tv", {16'd0, testValue}, 32'd0);
      end
      chk("rstw_ready_after", {31'd0, reqReady}, 32'd1);

      // Zero-wait build
      chk("z_idle_valid", {31'd0, zRspValid}, 32'd0);
      zReqValid = 1'b1;
      zReqWrite = 1'b1;
      zReqAddr  = 32'h4;
      zReqWdata = 32'hA5A5_0004;
      tick();
      zReqValid = 1'b0;
      chk("z_st_valid", {31'd0, zRspValid}, 32'd1);
      chk("z_st_err", {31'd0, zRspErr}, 32'd0);
      chk("z_st_ready", {31'd0, zReqReady}, 32'd0);
      tick();
      chk("z_idle_ready", {31'd0, zReqReady}, 32'd1);
      chk("z_tv", {16'd0, zTestValue}, 32'd0);
      zReqValid = 1'b1;
      zReqWrite = 1'b0;
      zReqAddr  = 32'h4;
      tick();
      zReqValid = 1'b0;
      chk("z_ld_valid", {31'd0, zRspValid}, 32'd1);
      chk("z_ld_rdata", zRspRdata, 32'hA5A5_0004);
      tick();
      chk("z_ld_done", {31'd0, zRspValid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               nVec, nErr);
      $finish;
   end

endmodule
